// File: rtl/sram_like_pkg.sv
// Shared encodings, response-entry type and parameter checks for the
// SRAM-like data-port slave.
package sram_like_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  cnt;
    } resp_entry_t;

    function automatic bit latency_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/data_sram_like_slave_if.sv
// CPU data-side SRAM-like bus: address phase (req/addr_ok) and in-order
// data phase (data_ok/rdata).
interface data_sram_like_slave_if;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// In-order response queue: QDEPTH circular buffer where every entry counts
// down its own latency independently of its position.
module sram_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int QDEPTH  = 2,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic [31:0] push_rdata,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic        head_ready,
    output resp_entry_t head
);

    localparam int         PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic [2:0]       cnt_q   [QDEPTH];
    logic [31:0]      rdata_q [QDEPTH];

    assign full       = (occ == (PTR_W+1)'(QDEPTH));
    assign empty      = (occ == '0);
    assign head.rdata = rdata_q[rd_ptr];
    assign head.cnt   = cnt_q[rd_ptr];
    assign head_ready = !empty && (head.cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < QDEPTH; i++) cnt_q[i] <= '0;
        end else begin
            // Idle slots keep decrementing to zero; a push always reloads its slot.
            for (int i = 0; i < QDEPTH; i++) begin
                if (push && (wr_ptr == PTR_W'(i))) cnt_q[i] <= CNT_INIT;
                else if (cnt_q[i] != '0)           cnt_q[i] <= cnt_q[i] - 3'd1;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) rdata_q[wr_ptr] <= push_rdata;
    end

endmodule

// File: rtl/data_sram_like_slave.sv
// Word-addressed RAM behind the SRAM-like data port; writes commit at
// address acceptance, responses return in order after LATENCY cycles.
module data_sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    data_sram_like_slave_if.slave  bus,
    input  logic                   addr_stall,
    input  logic                   data_stall
);

    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("data_sram_like_slave: LATENCY must be within 1..8");
    end

    logic [31:0]       ram [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              addr_ok;
    logic              accept;
    logic              data_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_ready;
    resp_entry_t       head;
    logic [31:0]       push_rdata;
    logic              unused_bits;

    assign idx = bus.data_sram_addr[ADDR_W+1:2];

    // Full is registered: a pop in the same cycle does not reopen addr_ok.
    assign addr_ok = resetn && !fifo_full && !addr_stall;
    assign accept  = bus.data_sram_req && addr_ok;
    assign data_ok = head_ready && !data_stall;

    assign bus.data_sram_addr_ok = addr_ok;
    assign bus.data_sram_data_ok = data_ok;
    assign bus.data_sram_rdata   = data_ok ? head.rdata : '0;

    // Reads sample the word as it stands before this edge's write (none for a read).
    assign push_rdata = bus.data_sram_wr ? '0 : ram[idx];

    always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wstrb[i]) ram[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    sram_resp_fifo #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_rdata (push_rdata),
        .pop        (data_ok),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_ready (head_ready),
        .head       (head)
    );

    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_W+2],
                           bus.data_sram_addr[1:0], fifo_empty, head.cnt};

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Bench for data_sram_like_slave: two instances (LATENCY 2 / QDEPTH 2 and
// LATENCY 1 / QDEPTH 4) against a timestamped in-order response model.
module tb_data_sram_like_slave;
    import sram_like_pkg::*;

    localparam int L0 = 2, Q0 = 2;
    localparam int L1 = 1, Q1 = 4;

    typedef struct packed {
        logic [31:0] rdata;
        bit          known;
        int          ready;
    } resp_t;

    logic clk = 1'b0;
    logic resetn;
    logic stall_a [2];
    logic stall_d [2];
    int   cyc = 0;
    int   checks = 0;
    int   errs = 0;

    data_sram_like_slave_if bus0 ();
    data_sram_like_slave_if bus1 ();

    data_sram_like_slave #(.ADDR_W(10), .LATENCY(L0), .QDEPTH(Q0)) u_dut0 (
        .clk(clk), .resetn(resetn), .bus(bus0), .addr_stall(stall_a[0]), .data_stall(stall_d[0]));
    data_sram_like_slave #(.ADDR_W(10), .LATENCY(L1), .QDEPTH(Q1)) u_dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1), .addr_stall(stall_a[1]), .data_stall(stall_d[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        aok [2], dok [2], mreq [2], mwr [2];
    logic [31:0] rd [2], maddr [2], mwd [2];
    logic [3:0]  mstb [2];
    assign aok[0] = bus0.data_sram_addr_ok;  assign aok[1] = bus1.data_sram_addr_ok;
    assign dok[0] = bus0.data_sram_data_ok;  assign dok[1] = bus1.data_sram_data_ok;
    assign rd[0]  = bus0.data_sram_rdata;    assign rd[1]  = bus1.data_sram_rdata;
    assign mreq[0] = bus0.data_sram_req;     assign mreq[1] = bus1.data_sram_req;
    assign mwr[0]  = bus0.data_sram_wr;      assign mwr[1]  = bus1.data_sram_wr;
    assign mstb[0] = bus0.data_sram_wstrb;   assign mstb[1] = bus1.data_sram_wstrb;
    assign maddr[0] = bus0.data_sram_addr;   assign maddr[1] = bus1.data_sram_addr;
    assign mwd[0]  = bus0.data_sram_wdata;   assign mwd[1]  = bus1.data_sram_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? L0 : L1;
    endfunction

    function automatic int qd_of(input int k);
        return (k == 0) ? Q0 : Q1;
    endfunction

    // Reference model: RAM image plus an ordered list of responses, each
    // stamped with the first cycle it may appear on the bus.
    logic [31:0] mram   [2][1024];
    bit          mknown [2][1024];
    resp_t       mq     [2][16];
    int          mhead  [2] = '{0, 0};
    int          mcnt   [2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic  e_aok, e_dok;
            resp_t h, ent;
            int    w;
            if (!resetn) begin
                mcnt[k] = 0;
                chk($sformatf("d%0d_rst_addr_ok", k), aok[k], 0);
                chk($sformatf("d%0d_rst_data_ok", k), dok[k], 0);
                chk($sformatf("d%0d_rst_rdata", k), rd[k], 0);
            end else begin
                h     = mq[k][mhead[k]];
                e_aok = (mcnt[k] < qd_of(k)) && !stall_a[k];
                e_dok = (mcnt[k] > 0) && (h.ready <= cyc) && !stall_d[k];
                chk($sformatf("d%0d_addr_ok", k), aok[k], e_aok);
                chk($sformatf("d%0d_data_ok", k), dok[k], e_dok);
                if (!e_dok)       chk($sformatf("d%0d_rdata_idle", k), rd[k], 0);
                else if (h.known) chk($sformatf("d%0d_rdata", k), rd[k], h.rdata);
                if (e_dok) begin
                    mhead[k] = (mhead[k] + 1) % 16;
                    mcnt[k]--;
                end
                if (mreq[k] && e_aok) begin
                    w = int'(maddr[k][11:2]);
                    ent.ready = cyc + lat_of(k);
                    if (mwr[k]) begin
                        ent.rdata = 32'h0;
                        ent.known = 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (mstb[k][b]) mram[k][w][8*b +: 8] = mwd[k][8*b +: 8];
                        if (mstb[k] == 4'hF) mknown[k][w] = 1'b1;
                    end else begin
                        ent.rdata = mram[k][w];
                        ent.known = mknown[k][w];
                    end
                    mq[k][(mhead[k] + mcnt[k]) % 16] = ent;
                    mcnt[k]++;
                end
            end
        end
    end

    task automatic drive(input int k, input bit r, input bit w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        logic [1:0] sz;
        sz = (s == 4'hF) ? SIZE_W : ((s == 4'h3 || s == 4'hC) ? SIZE_H : SIZE_B);
        if (k == 0) begin
            bus0.data_sram_req = r; bus0.data_sram_wr = w; bus0.data_sram_size = sz;
            bus0.data_sram_wstrb = s; bus0.data_sram_addr = a; bus0.data_sram_wdata = d;
        end else begin
            bus1.data_sram_req = r; bus1.data_sram_wr = w; bus1.data_sram_size = sz;
            bus1.data_sram_wstrb = s; bus1.data_sram_addr = a; bus1.data_sram_wdata = d;
        end
    endtask

    task automatic issue(input int k, input bit w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        drive(k, 1'b1, w, s, a, d);
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (aok[k]) begin got = 1'b1; acc = cyc; end
            @(posedge clk); #1;
        end
        drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (!got) chk("issue_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int k, input string tag, input logic [31:0] exp,
                             input int acc, input int lat);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (dok[k]) begin
                got = 1'b1;
                chk({tag, "_rdata"}, rd[k], exp);
                chk({tag, "_latency"}, cyc - acc, lat);
            end
            @(posedge clk); #1;
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n, first, last, drops, nstale;
        logic [31:0] got [4];
        logic [31:0] a;

        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            stall_a[k] = 1'b0;
            stall_d[k] = 1'b0;
            drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr_ok", aok[0], 0);
        chk("reset_data_ok", dok[0], 0);
        chk("reset_rdata", rd[0], 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single-word round trip
        issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, acc);
        wait_resp(0, "wr10", 32'h0, acc, 2);
        issue(0, 1'b0, 4'h0, 32'h10, 32'h0, acc);
        wait_resp(0, "rd10", 32'hDEADBEEF, acc, 2);

        // Byte strobes and unaligned read address
        issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, acc);
        wait_resp(0, "wr20", 32'h0, acc, 2);
        issue(0, 1'b1, 4'h2, 32'h20, 32'h0000AA00, acc);
        wait_resp(0, "wr20_b1", 32'h0, acc, 2);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0, acc);
        wait_resp(0, "rd20", 32'h1122AA44, acc, 2);
        issue(0, 1'b0, 4'h0, 32'h23, 32'h0, acc);
        wait_resp(0, "rd23", 32'h1122AA44, acc, 2);

        // Full queue with responses held back
        stall_d[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (aok[0]) n++;
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("full_accepts", n, 2);
        stall_d[0] = 1'b0;
        @(negedge clk);
        chk("full_pop1_data_ok", dok[0], 1);
        chk("full_pop1_rdata", rd[0], 32'hDEADBEEF);
        chk("full_pop1_addr_ok", aok[0], 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_pop2_data_ok", dok[0], 1);
        chk("full_pop2_rdata", rd[0], 32'hDEADBEEF);
        chk("full_pop2_addr_ok", aok[0], 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_drained", dok[0], 0);
        @(posedge clk); #1;

        // Streaming on the LATENCY=1 instance
        for (int i = 0; i < 8; i++) begin
            issue(1, 1'b1, 4'hF, 32'(4 * i), 32'(i), acc);
            wait_resp(1, "pre", 32'h0, acc, 1);
        end
        n = 0; first = -1; last = -1; drops = 0;
        for (int j = 0; j < 12; j++) begin
            if (j < 8) drive(1, 1'b1, 1'b0, 4'h0, 32'(4 * j), 32'h0);
            else       drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (j < 8 && !aok[1]) drops++;
            if (dok[1]) begin
                chk("stream_rdata", rd[1], 32'(n));
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        chk("stream_count", n, 8);
        chk("stream_span", last - first, 7);
        chk("stream_addr_ok_drops", drops, 0);

        // Read accepted the cycle after a write to the same word
        drive(0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h5A5A5A5A);
        @(negedge clk);
        chk("raw_w_addr_ok", aok[0], 1);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        @(negedge clk);
        chk("raw_r_addr_ok", aok[0], 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (dok[0] && n < 4) begin got[n] = rd[0]; n++; end
            @(posedge clk); #1;
        end
        chk("raw_count", n, 2);
        chk("raw_wresp", got[0], 32'h0);
        chk("raw_rresp", got[1], 32'h5A5A5A5A);

        // Reset while two reads are outstanding
        issue(0, 1'b1, 4'hF, 32'h80, 32'hCAFEF00D, acc);
        wait_resp(0, "wr80", 32'h0, acc, 2);
        drive(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("prerst_data_ok0", dok[0], 1);
        chk("prerst_addr_ok1", aok[1], 1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_data_ok0", dok[0], 0);
        chk("midrst_addr_ok0", aok[0], 0);
        chk("midrst_rdata0", rd[0], 0);
        chk("midrst_addr_ok1", aok[1], 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        nstale = 0;
        repeat (6) begin
            @(negedge clk);
            if (dok[0] || dok[1]) nstale++;
            @(posedge clk); #1;
        end
        chk("stale_data_ok", nstale, 0);
        issue(0, 1'b0, 4'h0, 32'h80, 32'h0, acc);
        wait_resp(0, "rd80_after_rst", 32'hCAFEF00D, acc, 2);

        // Fill a small region, then random traffic with stalls and aliasing
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 64; w++)
                issue(k, 1'b1, 4'hF, 32'(4 * w), $urandom, acc);
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++) begin
                a = $urandom;
                a[11:2] = 10'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0)
                    drive(k, 1'b1, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), a, $urandom);
                else
                    drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                stall_a[k] = ($urandom_range(0, 4) == 0);
                stall_d[k] = ($urandom_range(0, 4) == 0);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin
            drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            stall_a[k] = 1'b0;
            stall_d[k] = 1'b0;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("drain_idle_data_ok0", dok[0], 0);
        chk("drain_idle_data_ok1", dok[1], 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/data_sram_like_slave.md
Name: data_sram_like_slave

Overview:
- Responder end of the CPU data-side SRAM-like interface.
- Accepts requests from the EXE/MEM stages: address phase handshaked by `addr_ok`, data phase returned by `data_ok`/`rdata`, strictly in order.
- Backed by a word-addressed on-chip RAM with configurable response latency, a bounded outstanding-request queue and stall-injection inputs.
- Used as the data memory in core-level simulation and as a drop-in small DTCM.

Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words; RAM index = `data_sram_addr[ADDR_W+1:2]`.
- LATENCY, 2, cycles from address acceptance to earliest `data_ok`; legal range 1..8.
- QDEPTH, 2, max outstanding accepted-but-unanswered requests; power of two, 2..8.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_sram_req`  in  1  request valid.
- `data_sram_wr`  in  1  1 = write, 0 = read.
- `data_sram_size`  in  2  0 = byte, 1 = half, 2 = word; informational only, `wstrb` is authoritative.
- `data_sram_wstrb`  in  4  byte enables for writes.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  write data, already lane-aligned by the requester.
- `data_sram_addr_ok`  out  1  request accepted this cycle when high together with `req`.
- `data_sram_data_ok`  out  1  one response completes this cycle.
- `data_sram_rdata`  out  32  read word, valid only with `data_ok`.
- `addr_stall`  in  1  test hook; forces `addr_ok` low.
- `data_stall`  in  1  test hook; holds back `data_ok`.

Behaviour:
- Reset (`resetn` low, asynchronous):
  - queue emptied; `addr_ok`=0, `data_ok`=0, `rdata`=0.
  - RAM contents are not reset and are retained across reset.
- Address phase:
  - `addr_ok` = !full && !addr_stall && resetn-released; it does not depend on `req`.
  - Acceptance occurs on a rising edge with `req` && `addr_ok`.
  - The requester may drop or change `req` freely while `addr_ok` is low.
- On accept of a write:
  - each byte i with `wstrb[i]`=1 is written to the RAM at that edge; other bytes are unchanged.
  - a queue entry is pushed with rdata=0.
- On accept of a read:
  - the RAM word is sampled at that edge and pushed with the entry.
  - a read accepted in the cycle after a write to the same word returns the new data; no read-after-write hazard exists because writes commit at accept.
- Queue entry: {rdata[31:0], cnt[2:0]}; cnt loads LATENCY-1 on push and decrements by 1 each cycle while >0, independently per entry.
- Data phase:
  - `data_ok` = head valid && head.cnt==0 && !data_stall.
  - `rdata` = head.rdata when `data_ok`, else 0.
  - The requester never back-pressures: every `data_ok`-high cycle pops exactly one entry.
- Latency: a request accepted at edge E gets earliest `data_ok` in the cycle following E+(LATENCY-1) edges. With LATENCY=1 and empty queue, `data_ok` is high the cycle right after acceptance.
- Back-to-back throughput:
  - one accept and one response per cycle are sustainable.
  - push and pop on the same edge are allowed; occupancy is then unchanged.
- Full:
  - `addr_ok` is low when occupancy==QDEPTH, even if a pop happens this cycle (registered-full, no combinational bypass).
  - `addr_ok` rises the cycle after the pop.
- Empty: `data_ok` low.
- Ordering: responses are returned strictly in acceptance order, reads and writes mixed.
- Address bits above ADDR_W+1 are ignored (aliasing); bits [1:0] are ignored for RAM indexing.
- Reset asserted mid-transaction: outstanding entries are dropped with no `data_ok`. Writes already accepted stay committed.
- `data_stall` only delays; entry counters keep running, so a stalled head responds the first cycle `data_stall` drops.

Decomposition:
- Shared package `sram_like_pkg`:
  - SIZE_B/SIZE_H/SIZE_W encodings.
  - response entry struct {rdata, cnt}.
  - the LATENCY legal-range constant check.
- Natural sub-module: `sram_resp_fifo`, a QDEPTH circular buffer with per-entry countdown, full/empty flags and head-ready flag.
- RAM array, accept logic and byte-enable write stay in the top module.

Test Plan:
- Single word round trip, LATENCY=2, QDEPTH=2:
  - write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF → `data_ok` exactly 2 cycles after accept, rdata 0.
  - read 0x10 → `data_ok` 2 cycles later, rdata 0xDEADBEEF.
- Byte strobes:
  - word 0x20 = 0x11223344, then write wdata 0x0000AA00 with wstrb 0x2.
  - read 0x20 → rdata 0x1122AA44.
  - read 0x23 (unaligned byte address) → same word.
- Full queue:
  - hold `req` high with reads, `data_stall`=1 → `addr_ok` high for exactly 2 accepts, then low.
  - release `data_stall` → `data_ok` on 2 consecutive cycles, in order.
  - `addr_ok` returns high the cycle after the first pop.
- Streaming, LATENCY=1:
  - 8 back-to-back reads of 0x0..0x1C preloaded with index values → 8 consecutive `data_ok` cycles.
  - rdata 0..7 in order; `addr_ok` never drops.
- Read-after-write adjacency: write 0x40 = 0x5A5A5A5A accepted at edge E, read 0x40 accepted at E+1 → read response 0x5A5A5A5A.
- Reset mid-flight:
  - 2 outstanding reads, drop `resetn` asynchronously mid-cycle → `data_ok` and `addr_ok` go 0 immediately.
  - after release, no stale `data_ok`.
  - a write accepted before reset is readable afterwards.
